// File: rtl/rx_sync_ctrl_pkg.sv
// Shared types and constants for the rx_sync_ctrl word-alignment block.
package rx_sync_ctrl_pkg;

   localparam int OFFSET_W = 4;

   localparam logic [9:0] COMMA_P = 10'b0011111010;
   localparam logic [9:0] COMMA_N = 10'b1100000101;

   typedef enum logic [1:0] {
      ST_LOS  = 2'd0,
      ST_ACQ  = 2'd1,
      ST_SYNC = 2'd2
   } sync_state_e;

   function automatic logic is_comma(input logic [9:0] w);
      return (w == COMMA_P) || (w == COMMA_N);
   endfunction

   // Candidate 10b word starting k bits into the 20b {prev, cur} window.
   function automatic logic [9:0] window_slice(input logic [19:0] win,
                                               input logic [OFFSET_W-1:0] k);
      return win[19 - int'(k) -: 10];
   endfunction

endpackage

// File: rtl/rx_sync_ctrl_comma_detect.sv
// Combinational comma search over all ten bit offsets of a 20b window;
// reports whether any offset holds a comma and the lowest such offset.
module rx_comma_detect
   import rx_sync_ctrl_pkg::*;
(
   input  logic [19:0]         window,
   output logic                hit,
   output logic [OFFSET_W-1:0] k
);

   // Scan from the top so the lowest matching offset is the last one written.
   always_comb begin
      hit = 1'b0;
      k   = '0;
      for (int i = 9; i >= 0; i--) begin
         if (is_comma(window_slice(window, OFFSET_W'(i)))) begin
            hit = 1'b1;
            k   = OFFSET_W'(i);
         end
      end
   end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Receive word aligner and LOS/ACQ/SYNC link-sync state machine.
// Define RX_SYNC_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is 0.
module rx_sync_ctrl
   import rx_sync_ctrl_pkg::*;
#(
   parameter int COMMA_CNT = 3,
   parameter int ERR_MAX   = 4,
   parameter int GOOD_RUN  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] rx_word,
   input  logic       rx_valid,
   input  logic       code_err,
   output logic [9:0] aligned_word,
   output logic       aligned_valid,
   output logic       dec_en,
   output logic       sync_ok,
   output logic [3:0] align_offset,
   output logic [7:0] err_cnt
);

   localparam int CC_W   = $clog2(COMMA_CNT + 1);
   localparam int BAD_W  = $clog2(ERR_MAX + 1);
   localparam int GOOD_W = $clog2(GOOD_RUN + 1);

   sync_state_e         state_q, state_d;
   logic [9:0]          prev_q, prev_d;
   logic [19:0]         win_q, win_d;
   logic [19:0]         win_cur;
   logic [9:0]          aw_q, aw_d;
   logic                av_q, av_d;
   logic                sync_q;
   logic [OFFSET_W-1:0] off_q, off_d;
   logic [CC_W-1:0]     cc_q, cc_d;
   logic [BAD_W-1:0]    bad_q, bad_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic                hit;
   logic [OFFSET_W-1:0] hit_k;

   // Search runs on the window of the word currently on aligned_word, so
   // code_err and the comma decision for that word land in the same cycle.
   rx_comma_detect u_detect (
      .window (win_q),
      .hit    (hit),
      .k      (hit_k)
   );

   always_comb begin
      win_cur = {prev_q, rx_word};
      state_d = state_q;
      off_d   = off_q;
      cc_d    = cc_q;
      bad_d   = bad_q;
      good_d  = good_q;

      if (av_q) begin
         case (state_q)
            ST_LOS: begin
               if (hit) begin
                  off_d   = hit_k;
                  cc_d    = CC_W'(1);
                  state_d = ST_ACQ;
               end
            end
            ST_ACQ: begin
               if (code_err) begin
                  state_d = ST_LOS;
                  cc_d    = '0;
               end else if (is_comma(window_slice(win_q, off_q))) begin
                  if (int'(cc_q) + 1 >= COMMA_CNT) begin
                     state_d = ST_SYNC;
                     cc_d    = '0;
                     bad_d   = '0;
                     good_d  = '0;
                  end else begin
                     cc_d = cc_q + CC_W'(1);
                  end
               end else if (hit) begin
                  off_d = hit_k;
                  cc_d  = CC_W'(1);
               end
            end
            ST_SYNC: begin
               if (code_err) begin
                  good_d = '0;
                  if (int'(bad_q) + 1 >= ERR_MAX) begin
                     state_d = ST_LOS;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + BAD_W'(1);
                  end
               end else if (int'(good_q) + 1 >= GOOD_RUN) begin
                  good_d = '0;
                  if (bad_q != '0) bad_d = bad_q - BAD_W'(1);
               end else begin
                  good_d = good_q + GOOD_W'(1);
               end
            end
            default: state_d = ST_LOS;
         endcase
      end

      // The incoming word is cut with the offset that includes the word just judged.
      prev_d = rx_valid ? rx_word : prev_q;
      win_d  = rx_valid ? win_cur : win_q;
      aw_d   = rx_valid ? window_slice(win_cur, off_d) : aw_q;
      av_d   = rx_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOS;
         prev_q  <= '0;
         win_q   <= '0;
         aw_q    <= '0;
         av_q    <= 1'b0;
         sync_q  <= 1'b0;
         off_q   <= '0;
         cc_q    <= '0;
         bad_q   <= '0;
         good_q  <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         win_q   <= win_d;
         aw_q    <= aw_d;
         av_q    <= av_d;
         sync_q  <= (state_d == ST_SYNC);
         off_q   <= off_d;
         cc_q    <= cc_d;
         bad_q   <= bad_d;
         good_q  <= good_d;
      end
   end

`ifdef RX_SYNC_ERRCNT_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (av_q && code_err && (state_q == ST_SYNC) && (err_q != 8'hFF))
         err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= '0;
      else     err_q <= err_d;
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = '0;
`endif

   assign aligned_word  = aw_q;
   assign aligned_valid = av_q;
   assign sync_ok       = sync_q;
   assign dec_en        = av_q & sync_q;
   assign align_offset  = off_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Randomized bench for rx_sync_ctrl against a word-level reference model.
module tb_rx_sync_ctrl;

   localparam logic [9:0] CP = 10'b0011111010;
   localparam logic [9:0] CN = 10'b1100000101;
   localparam int COMMA_CNT = 3;
   localparam int ERR_MAX   = 4;
   localparam int GOOD_RUN  = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] rx_word;
   logic       rx_valid;
   logic       code_err;
   logic [9:0] aligned_word;
   logic       aligned_valid;
   logic       dec_en;
   logic       sync_ok;
   logic [3:0] align_offset;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   rx_sync_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .rx_word       (rx_word),
      .rx_valid      (rx_valid),
      .code_err      (code_err),
      .aligned_word  (aligned_word),
      .aligned_valid (aligned_valid),
      .dec_en        (dec_en),
      .sync_ok       (sync_ok),
      .align_offset  (align_offset),
      .err_cnt       (err_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: state 0 = LOS, 1 = ACQ, 2 = SYNC
   int          m_state, m_off, m_cc, m_bad, m_good, m_err;
   logic [9:0]  m_prev, m_aw;
   logic [19:0] m_win;
   logic        m_av;

   // Serializer side: symbols are sent with a bit slip of ph
   int          ph;
   logic [9:0]  last_sym;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic comma10(input logic [9:0] w);
      return (w == CP) || (w == CN);
   endfunction

   function automatic logic [9:0] at_off(input logic [19:0] win, input int k);
      return 10'((win >> (10 - k)) & 20'h3ff);
   endfunction

   function automatic int lowest(input logic [19:0] win);
      for (int k = 0; k < 10; k++)
         if (comma10(at_off(win, k))) return k;
      return -1;
   endfunction

   function automatic int exp_err();
`ifdef RX_SYNC_ERRCNT_EN
      return m_err;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_state = 0; m_off = 0; m_cc = 0; m_bad = 0; m_good = 0; m_err = 0;
      m_prev = '0; m_aw = '0; m_win = '0; m_av = 1'b0;
   endtask

   task automatic model_word(input logic [19:0] win, input logic err);
      int lk;
      lk = lowest(win);
      case (m_state)
         0: if (lk >= 0) begin m_off = lk; m_cc = 1; m_state = 1; end
         1: begin
            if (err) begin
               m_state = 0;
            end else if (comma10(at_off(win, m_off))) begin
               m_cc++;
               if (m_cc == COMMA_CNT) begin m_state = 2; m_bad = 0; m_good = 0; end
            end else if (lk >= 0) begin
               m_off = lk; m_cc = 1;
            end
         end
         default: begin
            if (err) begin
               if (m_err < 255) m_err++;
               m_good = 0;
               m_bad++;
               if (m_bad == ERR_MAX) begin m_state = 0; m_bad = 0; end
            end else begin
               m_good++;
               if (m_good == GOOD_RUN) begin
                  m_good = 0;
                  if (m_bad > 0) m_bad--;
               end
            end
         end
      endcase
   endtask

   task automatic step(input logic v, input logic [9:0] w, input logic e, input logic r);
      rst = r; rx_valid = v; rx_word = w; code_err = e;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (m_av) model_word(m_win, e);
         if (v) begin
            m_win  = {m_prev, w};
            m_prev = w;
            m_aw   = at_off(m_win, m_off);
         end
         m_av = v;
      end
      @(negedge clk);
      chk("aligned_valid", 32'(aligned_valid), 32'(m_av));
      chk("aligned_word",  32'(aligned_word),  32'(m_aw));
      chk("sync_ok",       32'(sync_ok),       32'(m_state == 2));
      chk("dec_en",        32'(dec_en),        32'(m_av && (m_state == 2)));
      chk("align_offset",  32'(align_offset),  32'(m_off));
      chk("err_cnt",       32'(err_cnt),       32'(exp_err()));
   endtask

   task automatic send(input logic [9:0] s, input logic e);
      logic [19:0] pair;
      pair     = {last_sym, s};
      last_sym = s;
      step(1'b1, 10'((pair >> ph) & 20'h3ff), e, 1'b0);
   endtask

   // Random symbol that creates no comma anywhere around it except nxt itself.
   function automatic logic [9:0] pick_filler(input logic [9:0] prv, input logic [9:0] nxt);
      logic [29:0] s;
      logic [9:0]  f;
      logic        ok;
      for (int t = 0; t < 200; t++) begin
         f  = 10'($urandom);
         s  = {prv, f, nxt};
         ok = 1'b1;
         for (int p = 28; p >= 11; p--)
            if (comma10(10'((s >> (p - 9)) & 30'h3ff))) ok = 1'b0;
         if (ok) return f;
      end
      return 10'h000;
   endfunction

   task automatic filler(input logic [9:0] nxt, input logic e);
      send(pick_filler(last_sym, nxt), e);
   endtask

   task automatic set_phase(input int p);
      if (p != ph) begin
         filler(10'h000, 1'b0);
         send(10'h000, 1'b0);
         ph = p;
         send(10'h000, 1'b0);
      end
   endtask

   // Three commas at slip p, then enough words for sync_ok to rise.
   task automatic acquire(input int p);
      set_phase(p);
      repeat (COMMA_CNT) begin
         filler(CP, 1'b0);
         send(CP, 1'b0);
      end
      filler(10'h000, 1'b0);
      filler(10'h000, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ph = 3;
      last_sym = '0;
      model_reset();

      // Reset state
      step(1'b0, 10'h000, 1'b0, 1'b1);
      chk("rst_sync_ok", 32'(sync_ok), 32'd0);
      chk("rst_offset",  32'(align_offset), 32'd0);

      // Three commas at offset 3 with random words in between
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(10'h000, 1'b0);
      chk("acq3_av",   32'(aligned_valid), 32'd1);
      chk("acq3_pre",  32'(sync_ok), 32'd0);
      filler(10'h000, 1'b0);
      chk("acq3_sync", 32'(sync_ok), 32'd1);
      chk("acq3_off",  32'(align_offset), 32'd3);

      // Comma at offset 3, then the stream slips to offset 7
      step(1'b1, 10'h000, 1'b0, 1'b1);
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(10'h000, 1'b0); send(10'h000, 1'b0);
      chk("relatch_off3", 32'(align_offset), 32'd3);
      ph = 7;
      send(10'h000, 1'b0);
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(CP, 1'b0); send(CP, 1'b0);
      chk("relatch_off7", 32'(align_offset), 32'd7);
      chk("relatch_s1",   32'(sync_ok), 32'd0);
      filler(CP, 1'b0); send(CP, 1'b0);
      chk("relatch_s2",   32'(sync_ok), 32'd0);
      filler(10'h000, 1'b0);
      chk("relatch_s3",   32'(sync_ok), 32'd0);
      filler(10'h000, 1'b0);
      chk("relatch_sync", 32'(sync_ok), 32'd1);

      // Four errors close together drop the link
      step(1'b0, 10'h000, 1'b0, 1'b1);
      ph = 3;
      acquire(3);
      chk("err4_pre", 32'(sync_ok), 32'd1);
      for (int i = 0; i < 4; i++) begin
         filler(10'h000, 1'b1);
         if (i < 3) filler(10'h000, 1'b0);
         if (i == 2) chk("err4_mid", 32'(sync_ok), 32'd1);
      end
      chk("err4_los", 32'(sync_ok), 32'd0);
`ifdef RX_SYNC_ERRCNT_EN
      chk("err4_cnt", 32'(err_cnt), 32'd4);
`else
      chk("err4_cnt", 32'(err_cnt), 32'd0);
`endif

      // 3 errors, a full good run, then one more error: still in sync
      step(1'b0, 10'h000, 1'b0, 1'b1);
      acquire(5);
      filler(10'h000, 1'b1); filler(10'h000, 1'b0);
      filler(10'h000, 1'b1); filler(10'h000, 1'b0);
      filler(10'h000, 1'b1);
      repeat (GOOD_RUN) filler(10'h000, 1'b0);
      filler(10'h000, 1'b1);
      chk("goodrun_sync", 32'(sync_ok), 32'd1);
      filler(10'h000, 1'b1);
      chk("goodrun_los",  32'(sync_ok), 32'd0);

      // Reset while in sync with a valid word present
      acquire(5);
      chk("rstsync_pre", 32'(sync_ok), 32'd1);
      step(1'b1, 10'($urandom), 1'b0, 1'b1);
      chk("rstsync_aw",  32'(aligned_word),  32'd0);
      chk("rstsync_av",  32'(aligned_valid), 32'd0);
      chk("rstsync_dec", 32'(dec_en),        32'd0);
      chk("rstsync_ok",  32'(sync_ok),       32'd0);
      chk("rstsync_off", 32'(align_offset),  32'd0);
      chk("rstsync_err", 32'(err_cnt),       32'd0);
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(CP, 1'b0); send(CP, 1'b0);
      filler(10'h000, 1'b0); filler(10'h000, 1'b0);
      chk("rstsync_reacq", 32'(sync_ok), 32'd0);

      // 300 errors across repeated resyncs
      step(1'b0, 10'h000, 1'b0, 1'b1);
      for (int r = 0; r < 75; r++) begin
         acquire($urandom_range(0, 9));
         repeat (4) filler(10'h000, 1'b1);
      end
`ifdef RX_SYNC_ERRCNT_EN
      chk("errsat", 32'(err_cnt), 32'd255);
`else
      chk("errsat", 32'(err_cnt), 32'd0);
`endif

      // Free-running random traffic with commas, gaps, errors and resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) ph = $urandom_range(0, 9);
         if ($urandom_range(0, 499) == 0)
            step(1'b1, 10'($urandom), 1'b0, 1'b1);
         else if ($urandom_range(0, 3) == 0)
            step(1'b0, 10'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
         else if ($urandom_range(0, 2) == 0)
            send(($urandom_range(0, 1) == 0) ? CP : CN, ($urandom_range(0, 15) == 0));
         else
            send(10'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
